spi_regbank: RTL and testbench

- Parametrised successor to the SPI demo's 16x8 memory. Register bank sits between the SPI shift engine and user logic.
- Shift-engine data is written from buffer_rx. Read data is returned on buffer_tx.
- Adds, over the fixed-size memory:
  - a hardware initialisation sweep;
  - burst auto-increment addressing;
  - per-address write protection;
  - error reporting.

---
 rtl/spi_regbank.sv | 78 +++++++
 tb/tb_spi_regbank.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// spi_regbank: parametrised register bank with init sweep, burst pointer, write protection and error pulses
module spi_regbank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit INIT_MODE = 1'b0,
  parameter logic [DEPTH-1:0] WP_MASK = '0
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_burst,
  input  logic [DATA_W-1:0] buffer_rx,
  output logic [DATA_W-1:0] buffer_tx,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic              mem_initial,
  output logic              mem_busy,
  output logic              mem_rd_valid,
  output logic              mem_err,
  output logic [ADDR_W-1:0] mem_ptr
);
  typedef enum logic {INIT, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, ptr_q, ptr_d, ea, ea_inc;
  logic [DATA_W-1:0] tx_q, tx_d, fill;
  logic busy_q, busy_d, rdv_q, rdv_d, err_q, err_d;
  logic acc, oob, wp, wr, last;
  logic [DATA_W-1:0] mem [DEPTH];
  always_comb begin
    ea = mem_burst ? ptr_q : mem_address;
    oob = 32'(ea) >= DEPTH;
    wp = !oob && WP_MASK[ea];
    acc = state_q == READY && mem_en && (mem_we || mem_re);
    wr = acc && mem_we && !oob && !wp;
    ea_inc = ea == ADDR_W'(DEPTH - 1) ? '0 : ea + 1'b1;
    ptr_d = acc && !oob ? ea_inc : ptr_q;
    rdv_d = acc && mem_re;
    tx_d = rdv_d ? (oob ? '0 : mem[ea]) : tx_q;
    err_d = acc ? (oob || (mem_we && wp)) : (state_q == INIT && mem_en && (mem_we || mem_re));
    last = idx_q == ADDR_W'(DEPTH - 1);
    state_d = state_q == INIT ? (last ? READY : INIT) : (mem_initial ? INIT : READY);
    idx_d = state_q == INIT && !last ? idx_q + 1'b1 : '0;
    busy_d = state_d == INIT;
    fill = INIT_MODE ? DATA_W'(idx_q) : INIT_VAL;
  end
  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state_q <= INIT;
      idx_q <= '0;
      ptr_q <= '0;
      tx_q <= '0;
      busy_q <= 1'b1;
      rdv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      rdv_q <= rdv_d;
      err_q <= err_d;
    end
  end
  // storage has no reset; only the sweep defines its contents
  always_ff @(posedge mem_clk) begin
    if (state_q == INIT) mem[idx_q] <= fill;
    else if (wr) mem[ea] <= buffer_rx;
  end
  assign buffer_tx = tx_q;
  assign mem_busy = busy_q;
  assign mem_rd_valid = rdv_q;
  assign mem_err = err_q;
  assign mem_ptr = ptr_q;
endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: directed checks of two spi_regbank instances (fill A5 with WP on 0, and fill-by-index)
module tb_spi_regbank;
  logic clk = 0, rst = 1, en = 0, burst = 0, we = 0, re = 0, init = 0;
  logic [3:0] addr = 0;
  logic [7:0] rx = 0;
  logic [7:0] tx0, tx1;
  logic busy0, busy1, rdv0, rdv1, err0, err1;
  logic [3:0] ptr0, ptr1;
  int errors = 0, checks = 0, n;
  always #5 clk = ~clk;
  spi_regbank #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'hA5), .INIT_MODE(1'b0), .WP_MASK(12'h001)) u0 (
    .mem_clk(clk), .mem_rst(rst), .mem_en(en), .mem_address(addr), .mem_burst(burst), .buffer_rx(rx),
    .buffer_tx(tx0), .mem_we(we), .mem_re(re), .mem_initial(init), .mem_busy(busy0),
    .mem_rd_valid(rdv0), .mem_err(err0), .mem_ptr(ptr0));
  spi_regbank #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(8'h00), .INIT_MODE(1'b1), .WP_MASK(12'h001)) u1 (
    .mem_clk(clk), .mem_rst(rst), .mem_en(en), .mem_address(addr), .mem_burst(burst), .buffer_rx(rx),
    .buffer_tx(tx1), .mem_we(we), .mem_re(re), .mem_initial(init), .mem_busy(busy1),
    .mem_rd_valid(rdv1), .mem_err(err1), .mem_ptr(ptr1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic acc(input logic w, input logic r, input logic b, input logic [3:0] a, input logic [7:0] d);
    we = w; re = r; burst = b; addr = a; rx = d;
    cyc();
    we = 0; re = 0; burst = 0;
  endtask
  task automatic count_busy(input string tag, input int start);
    n = start;
    while (busy0 && n < 50) begin
      cyc();
      n++;
    end
    chk(tag, n, 12);
  endtask
  initial begin
    cyc(); cyc();
    chk("rst_busy", busy0, 1);
    chk("rst_tx", tx0, 0);
    chk("rst_rdv", rdv0, 0);
    chk("rst_err", err0, 0);
    chk("rst_ptr", ptr0, 0);
    rst = 0; en = 1;
    count_busy("s1_busy_len", 0);
    for (int i = 0; i < 12; i++) begin
      acc(0, 1, 0, 4'(i), 0);
      chk("s1_rdv", rdv0, 1);
      chk("s1_tx", tx0, 8'hA5);
      chk("s1_tx_idx", tx1, i);
    end
    cyc();
    chk("s1_rdv_idle", rdv0, 0);
    acc(1, 0, 0, 4'd10, 8'hF0);
    chk("s2_wr_ptr", ptr0, 4'hB);
    chk("s2_wr_rdv", rdv0, 0);
    acc(0, 1, 0, 4'd10, 0);
    chk("s2_rd_tx", tx0, 8'hF0);
    chk("s2_rd_rdv", rdv0, 1);
    chk("s2_rd_ptr", ptr0, 4'hB);
    acc(1, 0, 0, 4'd10, 8'h11);
    chk("s3_ptr_set", ptr0, 4'd11);
    acc(1, 0, 1, 0, 8'h22);
    chk("s3_b1_ptr", ptr0, 0);
    chk("s3_b1_err", err0, 0);
    acc(1, 0, 1, 0, 8'h33);
    chk("s3_b2_ptr", ptr0, 1);
    chk("s3_b2_err", err0, 1);
    acc(1, 0, 1, 0, 8'h44);
    chk("s3_b3_ptr", ptr0, 2);
    chk("s3_b3_err", err0, 0);
    acc(0, 1, 0, 4'd11, 0);
    chk("s3_rd11", tx0, 8'h22);
    acc(0, 1, 0, 4'd0, 0);
    chk("s3_rd0", tx0, 8'hA5);
    acc(0, 1, 0, 4'd1, 0);
    chk("s3_rd1", tx0, 8'h44);
    acc(0, 1, 1, 4'd9, 0);
    chk("s3_brd_tx", tx0, 8'hA5);
    chk("s3_brd_ptr", ptr0, 3);
    acc(0, 1, 0, 4'd13, 0);
    chk("s4_oob_tx", tx0, 0);
    chk("s4_oob_rdv", rdv0, 1);
    chk("s4_oob_err", err0, 1);
    chk("s4_oob_ptr", ptr0, 3);
    acc(1, 0, 0, 4'd12, 8'h99);
    chk("s4_oobw_err", err0, 1);
    chk("s4_oobw_ptr", ptr0, 3);
    chk("s4_oobw_rdv", rdv0, 0);
    cyc();
    chk("s4_err_pulse", err0, 0);
    en = 0;
    acc(1, 1, 0, 4'd2, 8'h66);
    chk("s4_dis_rdv", rdv0, 0);
    chk("s4_dis_err", err0, 0);
    chk("s4_dis_ptr", ptr0, 3);
    en = 1;
    acc(0, 1, 0, 4'd2, 0);
    chk("s4_dis_nowr", tx0, 8'hA5);
    acc(1, 1, 0, 4'd0, 8'h55);
    chk("s4_wp_rw_tx", tx0, 8'hA5);
    chk("s4_wp_rw_err", err0, 1);
    chk("s4_wp_rw_rdv", rdv0, 1);
    acc(0, 1, 0, 4'd0, 0);
    chk("s4_wp_hold", tx0, 8'hA5);
    init = 1;
    cyc();
    chk("s5_busy_start", busy0, 1);
    acc(1, 1, 0, 4'd2, 8'h12);
    init = 0;
    chk("s5_busy_err", err0, 1);
    chk("s5_busy_rdv", rdv0, 0);
    chk("s5_busy_tx", tx0, 8'hA5);
    count_busy("s5_busy_len", 1);
    for (int i = 0; i < 12; i++) begin
      acc(0, 1, 0, 4'(i), 0);
      chk("s5_idx", tx1, i);
      chk("s5_fill", tx0, 8'hA5);
    end
    acc(0, 1, 0, 4'd4, 0);
    chk("s6_pre_ptr", ptr0, 5);
    init = 1;
    cyc();
    init = 0;
    repeat (5) cyc();
    rst = 1;
    #1;
    chk("s6_rst_busy", busy0, 1);
    chk("s6_rst_ptr", ptr0, 0);
    chk("s6_rst_tx", tx0, 0);
    chk("s6_rst_rdv", rdv0, 0);
    cyc(); cyc();
    rst = 0;
    count_busy("s6_busy_len", 0);
    acc(1, 1, 0, 4'd3, 8'h77);
    chk("s6_rbw_tx", tx0, 8'hA5);
    chk("s6_rbw_idx", tx1, 3);
    chk("s6_rbw_rdv", rdv0, 1);
    acc(0, 1, 0, 4'd3, 0);
    chk("s6_rd_new", tx0, 8'h77);
    chk("s6_rd_new1", tx1, 8'h77);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
